// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - pclk-domain SPI slave byte shifter, modes 0-3, MSB/LSB first
//
// Ports:
//   pclk, presetn            system clock, asynchronous active-low reset
//   sclk_in, ss_in, mosi_in  raw SPI pins from the master, synchronized here
//   spimode[1:0], lsbfe      {CPOL,CPHA} and bit order, captured at ss falling
//   spiswai                  wait mode: new frames are ignored
//   tx_data, tx_load         transmit buffer write strobe
//   miso_out, miso_oe        serial data to the master and its drive enable
//   rx_data, rx_valid        last received byte and its one-cycle update strobe
//   tx_empty, tx_underrun    buffer status, byte-started-empty strobe
//   frame_abort, busy        partial-byte deselect strobe, frame in progress

module spi_slave_shifter (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       sclk_in,
  input  logic       ss_in,
  input  logic       mosi_in,
  input  logic [1:0] spimode,
  input  logic       lsbfe,
  input  logic       spiswai,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       miso_out,
  output logic       miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_empty,
  output logic       tx_underrun,
  output logic       frame_abort,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] ss_sync_q, ss_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [1:0] settle_q, settle_d;
  logic       armed_q, armed_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic       lsb_q, lsb_d;
  logic       first_q, first_d;
  logic       und_pend_q, und_pend_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_empty_q, tx_empty_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic       tx_underrun_q, tx_underrun_d;
  logic       frame_abort_q, frame_abort_d;
  logic       miso_q, miso_d;

  logic       sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic       ss_fall, ss_rise, mosi_s;
  logic [7:0] load_val;
  logic       load_now;

  function automatic logic out_bit(input logic [7:0] v, input logic lsb);
    return lsb ? v[0] : v[7];
  endfunction

  // [1] is the synchronized value, [2] the extra copy used for edge detection
  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  // ss sync resets high, so a select already held low across reset release
  // would look like a falling edge; armed_q only rises once the synchronizer
  // carries real samples and has seen ss high.
  assign ss_fall     = armed_q & ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise     = ss_sync_q[1] & ~ss_sync_q[2];
  assign mosi_s      = mosi_sync_q[1];
  assign load_val    = tx_empty_q ? 8'h00 : tx_buf_q;

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[1:0], sclk_in};
    ss_sync_d     = {ss_sync_q[1:0], ss_in};
    mosi_sync_d   = {mosi_sync_q[0], mosi_in};
    settle_d      = {settle_q[0], 1'b1};
    armed_d       = armed_q | (settle_q[1] & ss_sync_q[1]);
    state_d       = state_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    lsb_d         = lsb_q;
    first_d       = first_q;
    und_pend_d    = und_pend_q;
    cnt_d         = cnt_q;
    rx_sr_d       = rx_sr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_buf_d      = tx_buf_q;
    tx_empty_d    = tx_empty_q;
    tx_sr_d       = tx_sr_q;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;
    miso_d        = miso_q;
    load_now      = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall && !spiswai) begin
          state_d       = ACTIVE;
          cpol_d        = spimode[1];
          cpha_d        = spimode[0];
          lsb_d         = lsbfe;
          cnt_d         = 3'd0;
          first_d       = spimode[0];
          load_now      = 1'b1;
          tx_underrun_d = tx_empty_q;
          // CPHA=0 must present the first bit before the first sclk edge
          if (!spimode[0]) miso_d = out_bit(load_val, lsbfe);
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d       = IDLE;
          miso_d        = 1'b0;
          cnt_d         = 3'd0;
          first_d       = 1'b0;
          und_pend_d    = 1'b0;
          frame_abort_d = (cnt_q != 3'd0);
        end else if (sample_edge) begin
          rx_sr_d = lsb_q ? {mosi_s, rx_sr_q[7:1]} : {rx_sr_q[6:0], mosi_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = rx_sr_d;
            rx_valid_d = 1'b1;
          end
          // a reloaded byte only counts as started once its first bit is clocked
          if (und_pend_q) begin
            tx_underrun_d = 1'b1;
            und_pend_d    = 1'b0;
          end
        end else if (shift_edge) begin
          if (first_q) begin
            // CPHA=1: byte already loaded at select, just drive its first bit
            miso_d  = out_bit(tx_sr_q, lsb_q);
            first_d = 1'b0;
          end else if (cnt_q == 3'd0) begin
            load_now   = 1'b1;
            und_pend_d = tx_empty_q;
            miso_d     = out_bit(load_val, lsb_q);
          end else begin
            tx_sr_d = lsb_q ? {1'b0, tx_sr_q[7:1]} : {tx_sr_q[6:0], 1'b0};
            miso_d  = out_bit(tx_sr_d, lsb_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_now) begin
      tx_sr_d    = load_val;
      tx_empty_d = 1'b1;
    end
    // a write in the same cycle as a load stays buffered for the next byte
    if (tx_load) begin
      tx_buf_d   = tx_data;
      tx_empty_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      sclk_sync_q   <= 3'b000;
      ss_sync_q     <= 3'b111;
      mosi_sync_q   <= 2'b00;
      settle_q      <= 2'b00;
      armed_q       <= 1'b0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      lsb_q         <= 1'b0;
      first_q       <= 1'b0;
      und_pend_q    <= 1'b0;
      cnt_q         <= 3'd0;
      rx_sr_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      tx_buf_q      <= 8'h00;
      tx_empty_q    <= 1'b1;
      tx_sr_q       <= 8'h00;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      settle_q      <= settle_d;
      armed_q       <= armed_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      lsb_q         <= lsb_d;
      first_q       <= first_d;
      und_pend_q    <= und_pend_d;
      cnt_q         <= cnt_d;
      rx_sr_q       <= rx_sr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_buf_q      <= tx_buf_d;
      tx_empty_q    <= tx_empty_d;
      tx_sr_q       <= tx_sr_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
      miso_q        <= miso_d;
    end
  end

  assign miso_out    = miso_q;
  assign miso_oe     = (state_q == ACTIVE);
  assign busy        = (state_q == ACTIVE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_empty    = tx_empty_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: doc/spi_slave_shifter.md
SPI_SLAVE_SHIFTER -- requirements
Module: spi_slave_shifter

Interface
REQ-001 Parameters: none; frame width SHALL be fixed at 8 bits.
REQ-002 pclk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-003 presetn  input  1  reset, asynchronous assert, active-low; it SHALL clear all state immediately, independent of pclk.
REQ-004 sclk_in  input  1  SPI serial clock from master, asynchronous to pclk.
REQ-005 ss_in  input  1  slave select from master, active-low, asynchronous.
REQ-006 mosi_in  input  1  serial data from master, asynchronous.
REQ-007 spimode  input  2  bit1 = CPOL (sclk idle level), bit0 = CPHA.
REQ-008 lsbfe  input  1  1 = LSB first, 0 = MSB first; sampled at frame start.
REQ-009 spiswai  input  1  wait mode; 1 = slave SHALL ignore new frames.
REQ-010 tx_data  input  8  byte to return on MISO.
REQ-011 tx_load  input  1  one-cycle strobe that writes tx_data into the transmit buffer.
REQ-012 miso_out  output  1  serial data to master.
REQ-013 miso_oe  output  1  MISO drive enable; 1 only while selected.
REQ-014 rx_data  output  8  last complete received byte.
REQ-015 rx_valid  output  1  one-pclk pulse when rx_data updates.
REQ-016 tx_empty  output  1  1 = transmit buffer holds no unsent byte.
REQ-017 tx_underrun  output  1  one-pclk pulse when a byte starts with an empty buffer.
REQ-018 frame_abort  output  1  one-pclk pulse when ss_in deasserts mid-byte.
REQ-019 busy  output  1  1 while in state ACTIVE.

Function
REQ-020 sclk_in, ss_in, mosi_in SHALL pass through 2-flop synchronizers; sclk edges SHALL be detected by comparing the synchronized value with one further registered copy.
REQ-021 sclk_in SHALL be at most pclk/4; faster operation is outside the requirements.
REQ-022 Leading edge = sclk transition away from CPOL; trailing edge = transition back to CPOL.
REQ-023 Sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; shift edge SHALL be the other one.
REQ-024 States SHALL be IDLE and ACTIVE; IDLE->ACTIVE on synchronized ss falling edge when spiswai=0; ACTIVE->IDLE on synchronized ss rising edge.
REQ-025 ss falling while spiswai=1 SHALL keep state IDLE for the entire select period; miso_oe SHALL remain 0.
REQ-026 On entry to ACTIVE, bit counter SHALL be 0, lsbfe SHALL be latched, and the shift register SHALL load the transmit buffer (or 8'h00 if tx_empty=1, with tx_underrun pulsed).
REQ-027 CPHA=0: first TX bit SHALL appear on miso_out in the first cycle of ACTIVE; later bits change on shift edges.
REQ-028 CPHA=1: each TX bit, including the first, SHALL change on a shift edge.
REQ-029 Each sample edge SHALL shift the synchronized mosi into the RX shift register and increment the 3-bit bit counter.
REQ-030 On the 8th sample edge, rx_data SHALL update in the next pclk cycle with rx_valid=1 for exactly that cycle; the counter SHALL wrap to 0.
REQ-031 When ss stays low after 8 bits, the next byte SHALL start: the shift register reloads from the buffer on the next shift edge (same underrun rule as REQ-026).
REQ-032 Loading the buffer into the shift register SHALL set tx_empty=1; tx_load SHALL set tx_empty=0; on simultaneous load and tx_load, the new tx_data SHALL stay buffered with tx_empty=0.
REQ-033 tx_load while tx_empty=0 SHALL overwrite the buffer.
REQ-034 ss rising with bit counter non-zero SHALL pulse frame_abort and discard the partial byte: no rx_valid, rx_data unchanged, counter reset.
REQ-035 In IDLE, miso_out SHALL be 0, miso_oe 0, and sclk edges SHALL be ignored.
REQ-036 spimode change during ACTIVE is unsupported; configuration SHALL be taken from the value present at ss falling.

Reset
REQ-037 On presetn=0: state IDLE, rx_data=8'h00, rx_valid=0, tx_empty=1, tx_underrun=0, frame_abort=0, busy=0, miso_out=0, miso_oe=0, counter=0, synchronizers cleared with ss sync=1 and sclk sync=0.
REQ-038 Reset asserted mid-frame SHALL abort immediately without frame_abort or rx_valid pulses; after release, the block SHALL wait for a fresh ss falling edge.

Verification
REQ-039 Mode 0, MSB first, tx_load 8'hA5, master sends 8'h3C -> rx_data=8'h3C with a single rx_valid pulse; master captures 8'hA5; tx_empty=1 afterwards.
REQ-040 Mode 3, LSB first, tx 8'h81, rx 8'h7E -> master captures 8'h81, rx_data=8'h7E.
REQ-041 Two bytes under one ss, tx 8'h11 then 8'h22 loaded mid-first-byte -> MISO 8'h11 then 8'h22, two rx_valid pulses, no tx_underrun.
REQ-042 No tx_load before frame -> tx_underrun pulse at start; MISO returns 8'h00.
REQ-043 ss raised after 5 bits -> frame_abort pulse, no rx_valid, rx_data keeps its previous value; the next full frame is received correctly.
REQ-044 spiswai=1 during ss low with 8 sclk pulses -> busy=0, miso_oe=0, no rx_valid; presetn pulsed mid-frame -> all outputs at REQ-037 values.
